// File: rtl/xadc_req_scheduler_if.sv
// Requester and XADC/DRP signal bundle for xadc_req_scheduler.
// The master modport is the scheduler's view. The slave modport is the view of
// the requesters plus the ADC.
interface xadc_req_scheduler_if #(
   parameter int N_REQ = 4
);
   // requester side
   logic [N_REQ-1:0]   Req;
   logic [7*N_REQ-1:0] Req_Addr;
   logic [N_REQ-1:0]   Ack;
   logic [15:0]        Rsp_Data;
   logic               Rsp_Err;
   logic               Busy;
   // XADC conversion / DRP side
   logic               ADC_SC;
   logic               ADC_Busy;
   logic               ADC_EOC;
   logic               Data_En;
   logic               Data_Rdy;
   logic [6:0]         ADC_Address;
   logic [15:0]        ADC_Data_in;

   modport master (
      input  Req, Req_Addr, ADC_Busy, ADC_EOC, Data_Rdy, ADC_Data_in,
      output Ack, Rsp_Data, Rsp_Err, Busy, ADC_SC, Data_En, ADC_Address
   );

   modport slave (
      output Req, Req_Addr, ADC_Busy, ADC_EOC, Data_Rdy, ADC_Data_in,
      input  Ack, Rsp_Data, Rsp_Err, Busy, ADC_SC, Data_En, ADC_Address
   );
endinterface

// File: rtl/xadc_req_scheduler.sv
// Round-robin scheduler sharing one XADC conversion/DRP port among N_REQ
// requesters. Each grant runs one conversion plus one register read. The
// result is returned with a one-cycle Ack to the winner. A saturating wait
// counter aborts a transaction when the ADC stays silent.
module xadc_req_scheduler #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                  Clk,
   input  logic                  Reset,
   xadc_req_scheduler_if.master  bus
);
   localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]    TMAX    = CW'(TIMEOUT);
   localparam logic [N_REQ-1:0] ONE_HOT = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE, START, WT_EOC, READ, WT_DRDY, DONE
   } state_t;

   state_t           state_q;
   logic [LW-1:0]    last_q;
   logic [LW-1:0]    gnt_q;
   logic [CW-1:0]    cnt_q;
   logic [N_REQ-1:0] ack_q;
   logic [15:0]      data_q;
   logic             err_q;
   logic             busy_q;
   logic             sc_q;
   logic             en_q;
   logic [6:0]       addr_q;

   // arbiter result, consumed only on the IDLE->START edge
   logic [LW-1:0]    win_d;
   logic             found_d;
   int               idx_d;

   // Round-robin scan starting one past the last grant, wrapping around.
   always_comb begin
      win_d   = last_q;
      found_d = 1'b0;
      idx_d   = 0;
      for (int off = 1; off <= N_REQ; off++) begin
         idx_d = int'(last_q) + off;
         if (idx_d >= N_REQ) idx_d = idx_d - N_REQ;
         if (!found_d && bus.Req[idx_d]) begin
            found_d = 1'b1;
            win_d   = LW'(idx_d);
         end
      end
   end

   // Transaction sequencer. All outputs are registered and set on the edge
   // that enters the state in which they are meant to be visible.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         last_q  <= LW'(N_REQ - 1);
         gnt_q   <= '0;
         cnt_q   <= '0;
         ack_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         sc_q    <= 1'b0;
         en_q    <= 1'b0;
         addr_q  <= '0;
      end else begin
         // single-cycle pulses drop by default
         sc_q  <= 1'b0;
         en_q  <= 1'b0;
         ack_q <= '0;
         case (state_q)
            IDLE: begin
               if (found_d && !bus.ADC_Busy) begin
                  state_q <= START;
                  gnt_q   <= win_d;
                  last_q  <= win_d;
                  addr_q  <= bus.Req_Addr[int'(win_d)*7 +: 7];
                  sc_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               state_q <= WT_EOC;
               cnt_q   <= '0;
            end
            WT_EOC: begin
               // an event in the expiry cycle still wins over the timeout
               if (bus.ADC_EOC) begin
                  state_q <= READ;
                  en_q    <= 1'b1;
               end else if (cnt_q == TMAX) begin
                  state_q <= DONE;
                  ack_q   <= ONE_HOT << gnt_q;
                  data_q  <= '0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
               end
            end
            READ: begin
               state_q <= WT_DRDY;
               cnt_q   <= '0;
            end
            WT_DRDY: begin
               if (bus.Data_Rdy) begin
                  state_q <= DONE;
                  ack_q   <= ONE_HOT << gnt_q;
                  data_q  <= bus.ADC_Data_in;
                  err_q   <= 1'b0;
               end else if (cnt_q == TMAX) begin
                  state_q <= DONE;
                  ack_q   <= ONE_HOT << gnt_q;
                  data_q  <= '0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Ack         = ack_q;
   assign bus.Rsp_Data    = data_q;
   assign bus.Rsp_Err     = err_q;
   assign bus.Busy        = busy_q;
   assign bus.ADC_SC      = sc_q;
   assign bus.Data_En     = en_q;
   assign bus.ADC_Address = addr_q;

endmodule

// File: tb/tb_xadc_req_scheduler.sv
// Self-checking bench for xadc_req_scheduler. It contains an ADC model with
// programmable EOC and DRDY latencies. A scoreboard queue holds one expected
// response per grant. It is filled when requests are driven and drained by
// the Ack monitor.
module tb_xadc_req_scheduler;
   localparam int N  = 4;
   localparam int TO = 15;

   typedef struct {
      logic [N-1:0] ack;
      logic [6:0]   addr;
      logic [15:0]  data;
      logic         err;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   always #5 Clk = ~Clk;

   xadc_req_scheduler_if #(.N_REQ(N)) bus ();

   xadc_req_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.master)
   );

   exp_t        sbq[$];
   int          errors = 0, checks = 0;
   int          cyc = 0, sc_cnt = 0, en_cnt = 0, sc_cyc = 0, ack_cyc = 0;
   int          eoc_dly = 5, drdy_dly = 2, stray_dly = -1;
   int          eoc_cnt = -1, drdy_cnt = -1, stray_cnt = -1;
   logic [6:0]  addr_tbl [N];
   logic [15:0] data_tbl [128];

   task automatic cycle_counter();
      forever @(posedge Clk) cyc++;
   endtask

   // ADC: EOC eoc_dly cycles after SC, DRDY drdy_dly cycles after Data_En,
   // a delay of -1 means the event never comes. Junk data is on the bus otherwise.
   task automatic adc_model();
      forever begin
         @(negedge Clk);
         bus.ADC_EOC     = 1'b0;
         bus.Data_Rdy    = 1'b0;
         bus.ADC_Data_in = 16'($urandom);
         if (Reset) begin
            eoc_cnt = -1; drdy_cnt = -1; stray_cnt = -1;
         end else begin
            if (bus.ADC_SC === 1'b1) begin
               eoc_cnt = eoc_dly; stray_cnt = stray_dly;
            end else begin
               if (eoc_cnt > 0) begin
                  eoc_cnt--;
                  if (eoc_cnt == 0) begin bus.ADC_EOC = 1'b1; eoc_cnt = -1; end
               end
               if (stray_cnt > 0) begin
                  stray_cnt--;
                  if (stray_cnt == 0) begin
                     bus.Data_Rdy = 1'b1; bus.ADC_Data_in = 16'hDEAD; stray_cnt = -1;
                  end
               end
            end
            if (bus.Data_En === 1'b1) drdy_cnt = drdy_dly;
            else if (drdy_cnt > 0) begin
               drdy_cnt--;
               if (drdy_cnt == 0) begin
                  bus.Data_Rdy = 1'b1; bus.ADC_Data_in = data_tbl[bus.ADC_Address]; drdy_cnt = -1;
               end
            end
         end
      end
   endtask

   // Ack monitor and scoreboard drain; also tallies SC / Data_En pulses.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge Clk);
         if (bus.ADC_SC === 1'b1) begin sc_cnt++; sc_cyc = cyc; end
         if (bus.Data_En === 1'b1) en_cnt++;
         if (bus.Ack !== '0) begin
            ack_cyc = cyc;
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ack got=%b exp=none", bus.Ack);
            end else begin
               e = sbq.pop_front();
               if (bus.Ack !== e.ack) begin
                  errors++; $display("FAIL ack got=%b exp=%b", bus.Ack, e.ack);
               end
               checks++;
               if (bus.ADC_Address !== e.addr) begin
                  errors++; $display("FAIL addr got=%h exp=%h", bus.ADC_Address, e.addr);
               end
               checks++;
               if (bus.Rsp_Data !== e.data) begin
                  errors++; $display("FAIL rsp_data got=%h exp=%h", bus.Rsp_Data, e.data);
               end
               checks++;
               if (bus.Rsp_Err !== e.err) begin
                  errors++; $display("FAIL rsp_err got=%b exp=%b", bus.Rsp_Err, e.err);
               end
            end
         end
      end
   endtask

   function automatic void push_exp(int idx, logic err);
      exp_t e;
      e.ack  = N'(1) << idx;
      e.addr = addr_tbl[idx];
      e.data = err ? 16'h0000 : data_tbl[addr_tbl[idx]];
      e.err  = err;
      sbq.push_back(e);
   endfunction

   task automatic set_addrs();
      for (int i = 0; i < N; i++) bus.Req_Addr[7*i +: 7] = addr_tbl[i];
   endtask

   task automatic apply_reset();
      bus.Req = '0;
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
   endtask

   // Counts Ack pulses, drops all Req once n have been seen.
   task automatic wait_acks(input int n, input int budget, input string name);
      int got = 0, k = 0;
      while (got < n && k < budget) begin
         @(negedge Clk);
         k++;
         if (bus.Ack !== '0) got++;
      end
      bus.Req = '0;
      #1;
      checks++;
      if (got < n) begin
         errors++; $display("FAIL %s_ack_count got=%0d exp=%0d", name, got, n);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      #1;
      checks++;
      if ({bus.Ack, bus.Rsp_Data, bus.Rsp_Err, bus.Busy, bus.ADC_SC, bus.Data_En, bus.ADC_Address} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {bus.Ack, bus.Rsp_Data, bus.Rsp_Err, bus.Busy, bus.ADC_SC, bus.Data_En, bus.ADC_Address});
      end
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_single();
      int sc0 = sc_cnt, en0 = en_cnt;
      eoc_dly = 5; drdy_dly = 2;
      push_exp(1, 1'b0);
      bus.Req = 4'b0010;
      wait_acks(1, 100, "single");
      checks++;
      if (sc_cnt - sc0 != 1) begin errors++; $display("FAIL single_sc_pulses got=%0d exp=1", sc_cnt - sc0); end
      checks++;
      if (en_cnt - en0 != 1) begin errors++; $display("FAIL single_en_pulses got=%0d exp=1", en_cnt - en0); end
      checks++;
      if (ack_cyc - sc_cyc != 9) begin errors++; $display("FAIL single_latency got=%0d exp=9", ack_cyc - sc_cyc); end
      @(negedge Clk);
      checks++;
      if (bus.Busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", bus.Busy); end
   endtask

   task automatic test_fairness();
      int ack0;
      apply_reset();
      eoc_dly = 2; drdy_dly = 1;
      for (int t = 0; t < 8; t++) push_exp(t % N, 1'b0);
      bus.Req = 4'b1111;
      ack0 = ack_cyc;
      wait_acks(8, 400, "fairness");
      checks++;
      if (ack_cyc == ack0) begin errors++; $display("FAIL fairness_no_ack got=%0d exp=new", ack_cyc); end
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_timeout();
      int en0 = en_cnt;
      eoc_dly = -1; drdy_dly = 1;
      push_exp(0, 1'b1);
      bus.Req = 4'b0001;
      repeat (3) @(negedge Clk);
      bus.Req_Addr[6:0] = 7'h7F; // late address change must not reach the ADC
      wait_acks(1, 100, "timeout");
      set_addrs();
      checks++;
      if (ack_cyc - sc_cyc != 17) begin errors++; $display("FAIL timeout_latency got=%0d exp=17", ack_cyc - sc_cyc); end
      checks++;
      if (en_cnt != en0) begin errors++; $display("FAIL timeout_data_en got=%0d exp=0", en_cnt - en0); end
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_timeout_tie();
      eoc_dly = 16; drdy_dly = 1;
      push_exp(0, 1'b0);
      bus.Req = 4'b0001;
      wait_acks(1, 100, "tie");
      checks++;
      if (ack_cyc - sc_cyc != 19) begin errors++; $display("FAIL tie_latency got=%0d exp=19", ack_cyc - sc_cyc); end
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_drdy_timeout();
      int en0 = en_cnt;
      eoc_dly = 2; drdy_dly = -1;
      push_exp(3, 1'b1);
      bus.Req = 4'b1000;
      wait_acks(1, 100, "drdy_timeout");
      checks++;
      if (ack_cyc - sc_cyc != 20) begin errors++; $display("FAIL drdy_timeout_latency got=%0d exp=20", ack_cyc - sc_cyc); end
      checks++;
      if (en_cnt - en0 != 1) begin errors++; $display("FAIL drdy_timeout_en got=%0d exp=1", en_cnt - en0); end
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_busy_gating();
      int sc0, f;
      eoc_dly = 6; drdy_dly = 3; stray_dly = 2;
      bus.ADC_Busy = 1'b1;
      push_exp(2, 1'b0);
      bus.Req = 4'b0100;
      sc0 = sc_cnt;
      repeat (10) @(negedge Clk);
      #1;
      checks++;
      if (sc_cnt != sc0) begin errors++; $display("FAIL busy_gate_sc got=%0d exp=0", sc_cnt - sc0); end
      checks++;
      if (bus.Busy !== 1'b0) begin errors++; $display("FAIL busy_gate_busy got=%b exp=0", bus.Busy); end
      bus.ADC_Busy = 1'b0;
      f = cyc;
      wait_acks(1, 100, "busy_gate");
      stray_dly = -1;
      checks++;
      if (sc_cyc != f + 1) begin errors++; $display("FAIL busy_gate_start got=%0d exp=%0d", sc_cyc, f + 1); end
      checks++;
      if (ack_cyc - sc_cyc != 11) begin errors++; $display("FAIL stray_drdy_latency got=%0d exp=11", ack_cyc - sc_cyc); end
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_reset_mid();
      int k = 0;
      eoc_dly = 3; drdy_dly = -1;
      bus.Req = 4'b0010;
      while (bus.Data_En !== 1'b1 && k < 50) begin @(negedge Clk); k++; end
      checks++;
      if (k >= 50) begin errors++; $display("FAIL reset_mid_no_data_en got=%0d exp=<50", k); end
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      #1;
      checks++;
      if ({bus.Ack, bus.Rsp_Data, bus.Rsp_Err, bus.Busy, bus.ADC_SC, bus.Data_En, bus.ADC_Address} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs got=%h exp=0",
                  {bus.Ack, bus.Rsp_Data, bus.Rsp_Err, bus.Busy, bus.ADC_SC, bus.Data_En, bus.ADC_Address});
      end
      bus.Req = '0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      eoc_dly = 2; drdy_dly = 1;
      push_exp(0, 1'b0);
      push_exp(3, 1'b0);
      bus.Req = 4'b1001;
      wait_acks(2, 100, "reset_mid");
      repeat (2) @(negedge Clk);
   endtask

   initial begin
      bus.Req = '0;
      bus.ADC_Busy = 1'b0;
      bus.ADC_EOC = 1'b0;
      bus.Data_Rdy = 1'b0;
      bus.ADC_Data_in = '0;
      for (int i = 0; i < 128; i++) data_tbl[i] = 16'(32'h1000 + i * 291);
      addr_tbl[0] = 7'h03; addr_tbl[1] = 7'h16; addr_tbl[2] = 7'h1E; addr_tbl[3] = 7'h4A;
      data_tbl[7'h16] = 16'hA5C0;
      set_addrs();
      fork
         cycle_counter();
         adc_model();
         monitor();
      join_none
      #1;
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_timeout_tie();
      test_drdy_timeout();
      test_busy_gating();
      test_reset_mid();
      checks++;
      if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", sbq.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
